pipelined_barrel_shifter: RTL and testbench

//  Parametrised, pipelined log-depth barrel shifter for the execute stage.

---
 rtl/pipelined_barrel_shifter_if.sv | 27 ++
 rtl/pipelined_barrel_shifter.sv | 72 +++++++
 tb/tb_pipelined_barrel_shifter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: operation handshake, flush and status bundle for the barrel shifter
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  localparam int SHAMT_W = $clog2(WIDTH);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [TAG_W-1:0]   in_tag;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;
  modport master (
    output in_valid, in_op, in_data, in_shamt, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag, busy
  );
  modport slave (
    input  in_valid, in_op, in_data, in_shamt, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log-depth SLL/SRL/SRA/ROR shifter with LPS mux levels per register stage
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int LPS   = 2,
  parameter int TAG_W = 5
) (
  input logic clk,
  input logic reset,
  pipelined_barrel_shifter_if.slave bs
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int STAGES  = (SHAMT_W + LPS - 1) / LPS;
  typedef logic [WIDTH-1:0] word_t;
  logic [STAGES-1:0]  v_q, v_d;
  logic [1:0]         op_q [STAGES];
  logic [1:0]         op_d [STAGES];
  logic [SHAMT_W-1:0] sh_q [STAGES];
  logic [SHAMT_W-1:0] sh_d [STAGES];
  word_t              d_q  [STAGES];
  word_t              d_d  [STAGES];
  logic [TAG_W-1:0]   t_q  [STAGES];
  logic [TAG_W-1:0]   t_d  [STAGES];
  logic               advance;
  function automatic word_t shift_by(word_t d, logic [1:0] op, int amt);
    return op == 2'b00 ? d << amt :
           op == 2'b01 ? d >> amt :
           op == 2'b10 ? word_t'($signed(d) >>> amt) :
                         (d >> amt) | (d << (WIDTH - amt));
  endfunction
  // each stage applies its own group of levels to the value latched by the previous stage
  always_comb begin
    v_d[0]  = bs.in_valid;
    op_d[0] = bs.in_op;
    sh_d[0] = bs.in_shamt;
    d_d[0]  = bs.in_data;
    t_d[0]  = bs.in_tag;
    for (int s = 1; s < STAGES; s++) begin
      v_d[s]  = v_q[s-1];
      op_d[s] = op_q[s-1];
      sh_d[s] = sh_q[s-1];
      d_d[s]  = d_q[s-1];
      t_d[s]  = t_q[s-1];
    end
    for (int k = 0; k < SHAMT_W; k++)
      d_d[k/LPS] = sh_d[k/LPS][k] ? shift_by(d_d[k/LPS], op_d[k/LPS], 1 << k) : d_d[k/LPS];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        op_q[s] <= '0;
        sh_q[s] <= '0;
        d_q[s]  <= '0;
        t_q[s]  <= '0;
      end
    end else begin
      if (advance) begin
        op_q <= op_d;
        sh_q <= sh_d;
        d_q  <= d_d;
        t_q  <= t_d;
      end
      v_q <= bs.flush ? '0 : advance ? v_d : v_q;
    end
  end
  assign advance      = !v_q[STAGES-1] | bs.out_ready;
  assign bs.in_ready  = advance & !bs.flush;
  assign bs.out_valid = v_q[STAGES-1];
  assign bs.out_data  = d_q[STAGES-1];
  assign bs.out_tag   = t_q[STAGES-1];
  assign bs.busy      = |v_q;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed and random scoreboard bench for pipelined_barrel_shifter
module tb_pipelined_barrel_shifter;
  localparam int WIDTH = 32, LPS = 2, TAG_W = 5, STAGES = 3;
  typedef logic [WIDTH-1:0] word_t;
  typedef struct {
    word_t            d;
    logic [TAG_W-1:0] t;
    logic             lat;
    int               acyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, failures = 0, cyc = 0, drain_n = 0;
  logic lat_mode = 1'b0, dir_on = 1'b0;
  word_t dir_exp = '0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic acc, s_ov, s_busy, s_rdy;
  word_t s_od;
  logic [TAG_W-1:0] s_ot;
  logic hold_v = 1'b0;
  word_t hold_d;
  logic [TAG_W-1:0] hold_t;
  logic [1:0] r_op;
  word_t r_d;
  logic [4:0] r_sh;

  pipelined_barrel_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bs ();
  pipelined_barrel_shifter #(.WIDTH(WIDTH), .LPS(LPS), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .bs(bs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic word_t model(logic [1:0] op, word_t d, int sh);
    logic [63:0] w;
    case (op)
      2'b00:   w = {32'b0, d} << sh;
      2'b01:   w = {32'b0, d} >> sh;
      2'b10:   w = {{32{d[31]}}, d} >> sh;
      default: w = {d, d} >> sh;
    endcase
    return w[31:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input word_t d, input logic [4:0] sh,
                       input logic [4:0] tg, input logic fl, input logic ordy);
    logic r;
    bs.in_valid = v; bs.in_op = op; bs.in_data = d; bs.in_shamt = sh; bs.in_tag = tg;
    bs.flush = fl; bs.out_ready = ordy;
    @(negedge clk);
    r = reset;
    acc = v && bs.in_ready && !r;
    s_ov = bs.out_valid; s_busy = bs.busy; s_rdy = bs.in_ready; s_od = bs.out_data; s_ot = bs.out_tag;
    if (acc) exp_q.push_back('{dir_on ? dir_exp : model(op, d, int'(sh)), tg, lat_mode, cyc});
    @(posedge clk);
    if (fl || r) exp_q.delete();
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    repeat (n) drive(1'b0, 2'b00, '0, '0, '0, 1'b0, ordy);
  endtask

  task automatic issue(input logic [1:0] op, input word_t d, input logic [4:0] sh, input logic [4:0] tg);
    drive(1'b1, op, d, sh, tg, 1'b0, 1'b1);
    chk("accept", acc, 1);
  endtask

  task automatic issue_k(input logic [1:0] op, input word_t d, input logic [4:0] sh, input logic [4:0] tg,
                         input word_t expected);
    dir_on = 1'b1; dir_exp = expected;
    issue(op, d, sh, tg);
    dir_on = 1'b0;
  endtask

  task automatic rnd();
    r_op = 2'($urandom); r_d = $urandom; r_sh = 5'($urandom);
  endtask

  always @(negedge clk) begin
    if (hold_v) begin
      chk("hold_valid", bs.out_valid, 1);
      chk("hold_data", bs.out_data, hold_d);
      chk("hold_tag", bs.out_tag, hold_t);
    end
    hold_v = bs.out_valid && !bs.out_ready && !bs.flush && !reset;
    hold_d = bs.out_data;
    hold_t = bs.out_tag;
    if (bs.out_valid && bs.out_ready && !reset) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output: got data %0h tag %0h, required no output", bs.out_data, bs.out_tag);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", bs.out_data, mon_e.d);
        chk("out_tag", bs.out_tag, mon_e.t);
        if (mon_e.lat) chk("latency", cyc - mon_e.acyc, STAGES);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle(2, 1'b1);
    reset = 1'b0;
    idle(1, 1'b1);
    chk("rst_out_valid", s_ov, 0);
    chk("rst_out_data", s_od, 0);
    chk("rst_out_tag", s_ot, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_in_ready", s_rdy, 1);

    lat_mode = 1'b1;
    issue_k(2'b01, 32'h8000_0000, 5'd16, 5'd7, 32'h0000_8000);
    issue_k(2'b10, 32'h8000_0000, 5'd31, 5'd8, 32'hFFFF_FFFF);
    issue_k(2'b01, 32'h8000_0000, 5'd31, 5'd9, 32'h0000_0001);
    issue_k(2'b00, 32'h0000_0001, 5'd31, 5'd10, 32'h8000_0000);
    issue_k(2'b11, 32'h1234_5678, 5'd8, 5'd11, 32'h7812_3456);
    issue_k(2'b11, 32'h1234_5678, 5'd0, 5'd12, 32'h1234_5678);
    issue_k(2'b10, 32'h7FFF_FFFF, 5'd4, 5'd13, 32'h07FF_FFFF);
    for (int i = 0; i < 4; i++) begin
      rnd();
      issue_k(r_op, r_d, 5'd0, 5'(14 + i), r_d);
    end
    lat_mode = 1'b0;
    idle(5, 1'b1);

    for (int i = 1; i <= 3; i++) begin
      rnd();
      drive(1'b1, r_op, r_d, r_sh, 5'(i), 1'b0, 1'b0);
      chk("t4_accept", acc, 1);
    end
    rnd();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, r_op, r_d, r_sh, 5'd4, 1'b0, 1'b0);
      chk("t4_stall_ready", s_rdy, 0);
      chk("t4_stall_valid", s_ov, 1);
    end
    drive(1'b1, r_op, r_d, r_sh, 5'd4, 1'b0, 1'b1);
    chk("t4_accept4", acc, 1);
    idle(6, 1'b1);

    for (int i = 0; i < 3; i++) begin
      rnd();
      issue(r_op, r_d, r_sh, 5'(20 + i));
    end
    rnd();
    drive(1'b1, r_op, r_d, r_sh, 5'd30, 1'b1, 1'b0);
    chk("t5_flush_reject", acc, 0);
    chk("t5_flush_ready", s_rdy, 0);
    lat_mode = 1'b1;
    rnd();
    issue(r_op, r_d, r_sh, 5'd31);
    chk("t5_out_valid", s_ov, 0);
    chk("t5_busy", s_busy, 0);
    lat_mode = 1'b0;
    idle(6, 1'b1);

    for (int i = 0; i < 3; i++) begin
      rnd();
      drive(1'b1, r_op, r_d, r_sh, 5'(24 + i), 1'b0, 1'b0);
    end
    reset = 1'b1;
    idle(1, 1'b0);
    reset = 1'b0;
    lat_mode = 1'b1;
    rnd();
    issue(r_op, r_d, r_sh, 5'd27);
    chk("t6_out_valid", s_ov, 0);
    chk("t6_out_data", s_od, 0);
    chk("t6_out_tag", s_ot, 0);
    chk("t6_busy", s_busy, 0);
    chk("t6_in_ready", s_rdy, 1);
    lat_mode = 1'b0;
    idle(6, 1'b1);

    for (int i = 0; i < 500; i++) begin
      rnd();
      drive($urandom_range(0, 3) != 0, r_op, r_d, r_sh, 5'($urandom), $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) < 7);
    end
    drain_n = 0;
    while ((exp_q.size() != 0 || bs.out_valid) && drain_n < 50) begin
      idle(1, 1'b1);
      drain_n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("final_busy", bs.busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
